if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. It generates the fetch PC and drives a request/response instruction-SRAM interface. It delivers IF_pc/IF_inst to the decode stage. It consumes the decode stage's branch/jump resolution signals to redirect fetch after the branch delay slot. It has one outstanding request, one output buffer, and honours ID_stall backpressure.

---
 rtl/if_stage_if.sv | 11 +
 rtl/if_stage.sv | 107 ++++++++++
 tb/tb_if_stage.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Instruction-SRAM request/response bus between the fetch stage and the SRAM.
interface if_stage_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (output inst_req, inst_addr, input inst_addr_ok, inst_data_ok, inst_rdata);
  modport slave  (input inst_req, inst_addr, output inst_addr_ok, inst_data_ok, inst_rdata);
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: one outstanding SRAM request, one output buffer,
// branch/jump redirect taking effect after the delay slot.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ID_stall,
  input  logic [31:0] ID_pc,
  input  logic        ID_br_taken,
  input  logic        ID_br_type,
  input  logic        ID_j_type,
  input  logic        ID_jr_type,
  input  logic [15:0] ID_br_index,
  input  logic [25:0] ID_j_index,
  input  logic [31:0] ID_jr_index,
  if_stage_if.master  isram,
  output logic [31:0] IF_pc,
  output logic [31:0] IF_inst
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]  state;
  logic [31:0] fetch_pc, issued_pc, out_pc, out_inst, ds_pc, tgt;
  logic        out_valid, pend;
  logic        consume, redirect, fire, data_in, ds_issued, pend_hit;
  logic [31:0] pc4, target;

  function automatic logic [31:0] branch_target(input logic [31:0] base,
                                                input logic [15:0] off);
    logic signed [31:0] soff;
    soff = {{14{off[15]}}, off, 2'b00};
    return base + $unsigned(soff);
  endfunction

  always_comb begin
    consume  = out_valid & ~ID_stall;
    redirect = ((ID_br_type & ID_br_taken) | ID_j_type | ID_jr_type) & ~ID_stall;
    pc4      = ID_pc + 32'd4;
    if (ID_jr_type)
      target = ID_jr_index;
    else if (ID_j_type)
      target = {pc4[31:28], ID_j_index, 2'b00};
    else
      target = branch_target(pc4, ID_br_index);
    // Delay slot already in flight or delivered: the redirect can apply at once.
    ds_issued = (fetch_pc == pc4 + 32'd4);
    pend_hit  = pend & (fetch_pc == ds_pc);

    isram.inst_req  = (state == S_REQ) & (~out_valid | consume) & ~redirect;
    isram.inst_addr = fetch_pc;
    fire    = isram.inst_req & isram.inst_addr_ok;
    data_in = (state == S_WAIT) & isram.inst_data_ok;

    IF_inst = out_valid ? out_inst : 32'd0;
    IF_pc   = out_valid ? out_pc   : RESET_PC;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      fetch_pc  <= RESET_PC;
      out_valid <= 1'b0;
      pend      <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  state <= S_REQ;
        S_REQ:   if (fire) state <= S_WAIT;
        S_WAIT:  if (data_in) state <= S_REQ;
        default: state <= S_IDLE;
      endcase

      if (fire)
        fetch_pc <= pend_hit ? tgt : fetch_pc + 32'd4;
      else if (redirect && ds_issued)
        fetch_pc <= target;

      if (fire && pend_hit)
        pend <= 1'b0;
      else if (redirect && !ds_issued)
        pend <= 1'b1;

      if (data_in)
        out_valid <= 1'b1;
      else if (consume)
        out_valid <= 1'b0;
    end
  end

  // Datapath registers carry no reset; their validity is qualified by control state.
  always_ff @(posedge clk) begin
    if (fire)
      issued_pc <= fetch_pc;
    if (data_in) begin
      out_inst <= isram.inst_rdata;
      out_pc   <= issued_pc;
    end
    if (redirect && !ds_issued) begin
      ds_pc <= pc4;
      tgt   <= target;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: SRAM and decode models plus a program-order reference.
module tb_if_stage;
  localparam logic [31:0] RPC = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ID_stall, ID_br_taken, ID_br_type, ID_j_type, ID_jr_type;
  logic [31:0] ID_pc, ID_jr_index;
  logic [15:0] ID_br_index;
  logic [25:0] ID_j_index;
  logic [31:0] IF_pc, IF_inst;

  if_stage_if bus();

  if_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .resetn(resetn), .ID_stall(ID_stall), .ID_pc(ID_pc),
    .ID_br_taken(ID_br_taken), .ID_br_type(ID_br_type), .ID_j_type(ID_j_type),
    .ID_jr_type(ID_jr_type), .ID_br_index(ID_br_index), .ID_j_index(ID_j_index),
    .ID_jr_index(ID_jr_index), .isram(bus), .IF_pc(IF_pc), .IF_inst(IF_inst)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9e3779b1) | 32'h1;
  endfunction

  // Reference state: next PC decode must receive, decode contents, pending redirect.
  logic [31:0] exp_pc, id_pc_m, id_jr_m, ds_addr, ds_tgt, outst_addr, prev_pc, prev_inst;
  logic [15:0] id_off;
  logic [25:0] id_jidx;
  logic        id_valid, ds_armed, last_branch, outst, prev_hold, first_req;
  int          id_kind, lat, delivered;

  task automatic model_reset();
    exp_pc = RPC; id_valid = 0; id_kind = 0; ds_armed = 0; last_branch = 0;
    outst = 0; lat = 0; prev_hold = 0; first_req = 1;
    ID_stall = 0; ID_pc = 0; ID_br_taken = 0; ID_br_type = 0; ID_j_type = 0;
    ID_jr_type = 0; ID_br_index = 0; ID_j_index = 0; ID_jr_index = 0;
    bus.inst_addr_ok = 0; bus.inst_data_ok = 0; bus.inst_rdata = 0;
  endtask

  task automatic load_decode(input logic [31:0] p);
    int r, soff;
    id_valid = 1; id_pc_m = p;
    id_off = 16'($urandom); id_jidx = 26'($urandom); id_jr_m = $urandom & 32'hfffffffc;
    r = last_branch ? 0 : $urandom_range(0, 7);
    case (r)
      4: id_kind = 1;
      5: id_kind = 2;
      6: id_kind = 3;
      7: id_kind = 4;
      default: id_kind = 0;
    endcase
    last_branch = (id_kind != 0);
    if (id_kind == 1 || id_kind == 3 || id_kind == 4) begin
      ds_armed = 1;
      ds_addr  = p + 32'd4;
      soff     = $signed(id_off);
      if (id_kind == 1)      ds_tgt = p + 32'd4 + 32'(soff * 4);
      else if (id_kind == 3) ds_tgt = ((p + 32'd4) & 32'hf0000000) | {4'b0, id_jidx, 2'b00};
      else                   ds_tgt = id_jr_m;
    end
  endtask

  task automatic run_cycle();
    logic valid, taken;
    @(posedge clk); #1;
    ID_stall    = ($urandom_range(0, 3) == 0);
    ID_pc       = id_valid ? id_pc_m : 32'd0;
    ID_br_type  = id_valid && (id_kind == 1 || id_kind == 2);
    ID_br_taken = id_valid && (id_kind == 1);
    ID_j_type   = id_valid && (id_kind == 3);
    ID_jr_type  = id_valid && (id_kind == 4);
    ID_br_index = id_off; ID_j_index = id_jidx; ID_jr_index = id_jr_m;
    bus.inst_addr_ok = ($urandom_range(0, 2) != 0);
    bus.inst_data_ok = 0;
    bus.inst_rdata   = $urandom;
    if (outst) begin
      if (lat == 0) begin
        bus.inst_data_ok = 1;
        bus.inst_rdata   = mem(outst_addr);
      end else lat--;
    end
    #3;
    valid = (IF_inst != 32'd0);
    taken = id_valid && (id_kind == 1 || id_kind == 3 || id_kind == 4);
    if (prev_hold) begin
      check("hold_pc", IF_pc, prev_pc);
      check("hold_inst", IF_inst, prev_inst);
    end
    if (!valid) check("bubble_pc", IF_pc, RPC);
    if (ID_stall && valid) check("stall_noreq", bus.inst_req, 1'b0);
    if (taken && !ID_stall) check("redir_noreq", bus.inst_req, 1'b0);
    if (bus.inst_req) begin
      check("align", bus.inst_addr[1:0], 2'b00);
      if (first_req) begin
        check("first_addr", bus.inst_addr, RPC);
        first_req = 0;
      end
    end
    if (bus.inst_data_ok) outst = 0;
    if (bus.inst_req && bus.inst_addr_ok) begin
      check("one_outstanding", outst, 1'b0);
      outst = 1; outst_addr = bus.inst_addr; lat = $urandom_range(0, 2);
    end
    if (!ID_stall) begin
      if (valid) begin
        check("order_pc", IF_pc, exp_pc);
        check("inst", IF_inst, mem(IF_pc));
        delivered++;
        if (ds_armed && IF_pc == ds_addr) begin
          exp_pc = ds_tgt; ds_armed = 0;
        end else exp_pc = IF_pc + 32'd4;
        load_decode(IF_pc);
      end else begin
        id_valid = 0; id_kind = 0;
      end
    end
    prev_hold = valid && ID_stall;
    prev_pc = IF_pc; prev_inst = IF_inst;
  endtask

  initial begin
    model_reset();
    delivered = 0;
    #12;
    check("rst_inst", IF_inst, 32'd0);
    check("rst_pc", IF_pc, RPC);
    check("rst_req", bus.inst_req, 1'b0);
    @(negedge clk); resetn = 1;

    for (int i = 0; i < 400; i++) run_cycle();
    check("progress1", delivered >= 20, 1'b1);

    // Drive into a cycle with a request in flight, then reset asynchronously.
    for (int i = 0; i < 50 && !outst; i++) run_cycle();
    check("outst_reached", outst, 1'b1);
    @(posedge clk); #2;
    resetn = 0;
    model_reset();
    #1;
    check("mid_rst_inst", IF_inst, 32'd0);
    check("mid_rst_pc", IF_pc, RPC);
    check("mid_rst_req", bus.inst_req, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); resetn = 1;

    delivered = 0;
    for (int i = 0; i < 400; i++) run_cycle();
    check("progress2", delivered >= 20, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
